branch_stall_sequencer: RTL and testbench

//  ID-stage branch hazard controller for the 5-stage RV32I pipeline.
//  - Decides whether a branch in ID must stall (0, 1 or 2 cycles) and sequences those stalls with a small FSM.
//  - Drives the branch comparator forwarding selects for the cycle in which the branch is evaluated.
//  - Issues the IF flush on a taken branch.
//  - Keeps saturating counters of stall cycles, resolved branches and taken branches.

---
 rtl/branch_stall_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_branch_stall_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_stall_sequencer.sv
// branch_stall_sequencer
//   Branch hazard controller for the ID stage of a 5-stage RV32I pipeline. A branch
//   in ID is compared in ID, so its operands must already be available there.
//   Depending on the producer it waits 0, 1 or 2 cycles before the branch is evaluated.
//   A two-process FSM sequences those stall cycles.
//   The block also drives the comparator forwarding selects and the IF flush on a
//   taken branch. It keeps saturating counts of stall cycles, resolved branches and
//   taken branches.
//
// Ports
//   clk, rst_n                     clock and synchronous active-low reset
//   Branch, flush_ID               branch decoded in ID; external squash of ID
//   rs1, rs2                       ID source registers
//   rd_EX, RegWrite_EX, MemRead_EX     EX-stage producer info
//   rd_MEM, RegWrite_MEM, MemRead_MEM  MEM-stage producer info
//   branch_taken                   comparator result, used only in the evaluate cycle
//   PCWrite, IDWrite, CtrlSrc      stall controls (CtrlSrc = 1 injects a bubble)
//   IF_flush                       squash the fetched instruction on a taken branch
//   branch_forwardA/B              10 = EX, 01 = MEM, 00 = register file
//   busy                           FSM not idle
//   stall_cnt, br_cnt, taken_cnt   saturating performance counters

module branch_stall_sequencer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Branch,
  input  logic             flush_ID,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rd_EX,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [4:0]       rd_MEM,
  input  logic             RegWrite_MEM,
  input  logic             MemRead_MEM,
  input  logic             branch_taken,
  output logic             PCWrite,
  output logic             IDWrite,
  output logic             CtrlSrc,
  output logic             IF_flush,
  output logic [1:0]       branch_forwardA,
  output logic [1:0]       branch_forwardB,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {StIdle, StStall, StResolve} state_e;

  localparam logic [1:0] SelRf  = 2'b00;
  localparam logic [1:0] SelMem = 2'b01;
  localparam logic [1:0] SelEx  = 2'b10;

  state_e           state_q, state_d;
  logic             rem_q, rem_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  // Operand match terms; x0 never matches.
  logic ex_a, ex_b, ex_any, mem_a, mem_b, mem_any;
  logic haz2, haz1_ex, haz1_mem;

  always_comb begin
    ex_a     = (rd_EX != 5'd0) && (rd_EX == rs1);
    ex_b     = (rd_EX != 5'd0) && (rd_EX == rs2);
    ex_any   = ex_a | ex_b;
    mem_a    = (rd_MEM != 5'd0) && (rd_MEM == rs1);
    mem_b    = (rd_MEM != 5'd0) && (rd_MEM == rs2);
    mem_any  = mem_a | mem_b;
    haz2     = RegWrite_EX & MemRead_EX & ex_any;
    haz1_ex  = RegWrite_EX & ~MemRead_EX & ex_any;
    haz1_mem = RegWrite_MEM & MemRead_MEM & mem_any;
  end

  logic eval;

  always_comb begin
    state_d         = state_q;
    rem_d           = rem_q;
    fwd_a_d         = fwd_a_q;
    fwd_b_d         = fwd_b_q;
    PCWrite         = 1'b1;
    IDWrite         = 1'b1;
    CtrlSrc         = 1'b0;
    IF_flush        = 1'b0;
    branch_forwardA = SelRf;
    branch_forwardB = SelRf;
    eval            = 1'b0;

    if (flush_ID || !rst_n) begin
      // Squash or reset: drop the sequence, outputs stay at defaults.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Branch) begin
            if (haz2 || haz1_ex || haz1_mem) begin
              PCWrite = 1'b0;
              IDWrite = 1'b0;
              CtrlSrc = 1'b1;
              if (haz2) begin
                rem_d   = 1'b1;
                fwd_a_d = SelRf;
                fwd_b_d = SelRf;
                state_d = StStall;
              end else if (haz1_ex) begin
                // The EX ALU result will sit in MEM during the resolve cycle.
                fwd_a_d = ex_a ? SelMem : SelRf;
                fwd_b_d = ex_b ? SelMem : SelRf;
                state_d = StResolve;
              end else begin
                // The MEM load will be in WB; the register file writes before it is read.
                fwd_a_d = SelRf;
                fwd_b_d = SelRf;
                state_d = StResolve;
              end
            end else begin
              eval = 1'b1;
              if (RegWrite_EX && ex_a) begin
                branch_forwardA = SelEx;
              end else if (RegWrite_MEM && !MemRead_MEM && mem_a) begin
                branch_forwardA = SelMem;
              end
              if (RegWrite_EX && ex_b) begin
                branch_forwardB = SelEx;
              end else if (RegWrite_MEM && !MemRead_MEM && mem_b) begin
                branch_forwardB = SelMem;
              end
            end
          end
        end
        StStall: begin
          PCWrite = 1'b0;
          IDWrite = 1'b0;
          CtrlSrc = 1'b1;
          rem_d   = 1'b0;
          fwd_a_d = SelRf;
          fwd_b_d = SelRf;
          state_d = StResolve;
        end
        StResolve: begin
          eval            = 1'b1;
          branch_forwardA = fwd_a_q;
          branch_forwardB = fwd_b_q;
          state_d         = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
      IF_flush = eval & branch_taken;
    end
  end

  // Saturating counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (CtrlSrc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (eval && (br_cnt_q != '1)) begin
      br_cnt_d = br_cnt_q + 1'b1;
    end
    if (eval && branch_taken && (taken_cnt_q != '1)) begin
      taken_cnt_d = taken_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rem_q       <= 1'b0;
      fwd_a_q     <= SelRf;
      fwd_b_q     <= SelRf;
      stall_cnt_q <= '0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign stall_cnt = stall_cnt_q;
  assign br_cnt    = br_cnt_q;
  assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_stall_sequencer.sv
module tb_branch_stall_sequencer;

  localparam int unsigned CntW = 4;

  logic            clk;
  logic            rst_n;
  logic            Branch;
  logic            flush_ID;
  logic [4:0]      rs1, rs2, rd_EX, rd_MEM;
  logic            RegWrite_EX, MemRead_EX, RegWrite_MEM, MemRead_MEM;
  logic            branch_taken;
  logic            PCWrite, IDWrite, CtrlSrc, IF_flush, busy;
  logic [1:0]      branch_forwardA, branch_forwardB;
  logic [CntW-1:0] stall_cnt, br_cnt, taken_cnt;

  int n_cmp;
  int n_bad;

  branch_stall_sequencer #(.CNT_W(CntW)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .Branch          (Branch),
    .flush_ID        (flush_ID),
    .rs1             (rs1),
    .rs2             (rs2),
    .rd_EX           (rd_EX),
    .RegWrite_EX     (RegWrite_EX),
    .MemRead_EX      (MemRead_EX),
    .rd_MEM          (rd_MEM),
    .RegWrite_MEM    (RegWrite_MEM),
    .MemRead_MEM     (MemRead_MEM),
    .branch_taken    (branch_taken),
    .PCWrite         (PCWrite),
    .IDWrite         (IDWrite),
    .CtrlSrc         (CtrlSrc),
    .IF_flush        (IF_flush),
    .branch_forwardA (branch_forwardA),
    .branch_forwardB (branch_forwardB),
    .busy            (busy),
    .stall_cnt       (stall_cnt),
    .br_cnt          (br_cnt),
    .taken_cnt       (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    Branch       = 1'b0;
    flush_ID     = 1'b0;
    rs1          = 5'd0;
    rs2          = 5'd0;
    rd_EX        = 5'd0;
    RegWrite_EX  = 1'b0;
    MemRead_EX   = 1'b0;
    rd_MEM       = 5'd0;
    RegWrite_MEM = 1'b0;
    MemRead_MEM  = 1'b0;
    branch_taken = 1'b0;
  endtask

  // Advance to just after the next rising edge; inputs then settle before checks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic pcw, input logic cs,
                           input logic fl, input logic [1:0] fa, input logic [1:0] fb);
    #1;
    check_eq({tag, ".PCWrite"}, {31'd0, PCWrite}, {31'd0, pcw});
    check_eq({tag, ".IDWrite"}, {31'd0, IDWrite}, {31'd0, pcw});
    check_eq({tag, ".CtrlSrc"}, {31'd0, CtrlSrc}, {31'd0, cs});
    check_eq({tag, ".IF_flush"}, {31'd0, IF_flush}, {31'd0, fl});
    check_eq({tag, ".fwdA"}, {30'd0, branch_forwardA}, {30'd0, fa});
    check_eq({tag, ".fwdB"}, {30'd0, branch_forwardB}, {30'd0, fb});
  endtask

  task automatic check_cnt(input string tag, input int st, input int br, input int tk);
    check_eq({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(st));
    check_eq({tag, ".br_cnt"}, 32'(br_cnt), 32'(br));
    check_eq({tag, ".taken_cnt"}, 32'(taken_cnt), 32'(tk));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clear_in();
    rst_n = 1'b0;
    tick();
    tick();
    check_eq("rst.busy", {31'd0, busy}, 32'd0);
    check_cnt("rst", 0, 0, 0);
    check_ctl("rst", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    rst_n = 1'b1;
    tick();

    // add x5 ; beq x5,x6 -> one stall, then resolve with fwdA = MEM, taken.
    Branch = 1'b1; rs1 = 5'd5; rs2 = 5'd6; rd_EX = 5'd5; RegWrite_EX = 1'b1;
    check_ctl("t1.stall", 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    rd_EX = 5'd0; RegWrite_EX = 1'b0; rd_MEM = 5'd5; RegWrite_MEM = 1'b1;
    branch_taken = 1'b1;
    check_eq("t1.busy", {31'd0, busy}, 32'd1);
    check_ctl("t1.resolve", 1'b1, 1'b0, 1'b1, 2'b01, 2'b00);
    tick();
    clear_in();
    check_eq("t1.idle", {31'd0, busy}, 32'd0);
    check_cnt("t1", 1, 1, 1);

    // lw x7 ; bne x0,x7 -> two stalls, resolve from register file, not taken.
    Branch = 1'b1; rs1 = 5'd0; rs2 = 5'd7; rd_EX = 5'd7; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
    check_ctl("t2.idle", 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    rd_EX = 5'd0; RegWrite_EX = 1'b0; MemRead_EX = 1'b0;
    rd_MEM = 5'd7; RegWrite_MEM = 1'b1; MemRead_MEM = 1'b1;
    check_eq("t2.busy", {31'd0, busy}, 32'd1);
    check_ctl("t2.stall", 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    rd_MEM = 5'd0; RegWrite_MEM = 1'b0; MemRead_MEM = 1'b0;
    check_ctl("t2.resolve", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    tick();
    clear_in();
    check_cnt("t2", 3, 2, 1);

    // lw x7 ; nop ; beq x7,x7 -> H1 via MEM load, one stall, select 00, taken.
    Branch = 1'b1; rs1 = 5'd7; rs2 = 5'd7;
    rd_MEM = 5'd7; RegWrite_MEM = 1'b1; MemRead_MEM = 1'b1;
    check_ctl("t3.stall", 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    rd_MEM = 5'd0; RegWrite_MEM = 1'b0; MemRead_MEM = 1'b0; branch_taken = 1'b1;
    check_ctl("t3.resolve", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    tick();
    clear_in();
    check_cnt("t3", 4, 3, 2);

    // add x9 ; unrelated ; beq x9,x9 -> no stall, both operands from MEM.
    Branch = 1'b1; rs1 = 5'd9; rs2 = 5'd9; rd_EX = 5'd3; RegWrite_EX = 1'b1;
    rd_MEM = 5'd9; RegWrite_MEM = 1'b1;
    check_ctl("t4.eval", 1'b1, 1'b0, 1'b0, 2'b01, 2'b01);
    check_eq("t4.busy", {31'd0, busy}, 32'd0);
    tick();
    clear_in();
    check_cnt("t4", 4, 4, 2);

    // Branch on x0 with a write to x0 in EX -> no stall, selects 00, taken.
    Branch = 1'b1; rd_EX = 5'd0; RegWrite_EX = 1'b1; branch_taken = 1'b1;
    check_ctl("t5.eval", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    tick();
    clear_in();
    check_cnt("t5", 4, 5, 3);

    // flush_ID during STALL -> defaults this cycle, IDLE next, nothing counted.
    Branch = 1'b1; rs1 = 5'd4; rd_EX = 5'd4; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
    tick();
    clear_in();
    flush_ID = 1'b1;
    check_eq("t6.busy", {31'd0, busy}, 32'd1);
    check_ctl("t6.flush", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    tick();
    clear_in();
    check_eq("t6.idle", {31'd0, busy}, 32'd0);
    check_cnt("t6", 5, 5, 3);

    // flush_ID during RESOLVE overrides branch_taken.
    Branch = 1'b1; rs1 = 5'd5; rd_EX = 5'd5; RegWrite_EX = 1'b1;
    tick();
    clear_in();
    flush_ID = 1'b1; branch_taken = 1'b1;
    check_ctl("t7.flush", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    tick();
    clear_in();
    check_eq("t7.idle", {31'd0, busy}, 32'd0);
    check_cnt("t7", 6, 5, 3);

    // Reset during STALL -> defaults this cycle, IDLE and cleared counters next.
    Branch = 1'b1; rs2 = 5'd8; rd_EX = 5'd8; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
    tick();
    clear_in();
    rst_n = 1'b0;
    check_ctl("t8.rst", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    tick();
    rst_n = 1'b1;
    check_eq("t8.idle", {31'd0, busy}, 32'd0);
    check_cnt("t8", 0, 0, 0);

    // Back-to-back H2 branches: 2 stalls + 1 taken resolve per 3 cycles.
    // 48 cycles gives 32 stalls and 16 branches, all past the 4-bit ceiling.
    Branch = 1'b1; rs1 = 5'd2; rd_EX = 5'd2; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
    branch_taken = 1'b1;
    for (int i = 0; i < 48; i++) begin
      tick();
    end
    check_eq("t9.busy", {31'd0, busy}, 32'd0);
    check_cnt("t9.sat", 15, 15, 15);
    tick();
    check_cnt("t9.hold", 15, 15, 15);
    clear_in();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
